// File: rtl/clk_div_cfg_ctrl_if.sv
// Config/handshake bundle between the clock-control register block, the
// divider sequencer and the integer divider plus clock gate.
interface clk_div_cfg_ctrl_if #(
   parameter int DIV_VALUE_WIDTH = 32
);
   logic [DIV_VALUE_WIDTH-1:0] cfg_div_i;
   logic                       cfg_init_i;
   logic                       cfg_valid_i;
   logic                       cfg_ready_o;
   logic [DIV_VALUE_WIDTH-1:0] div_o;
   logic                       clk_init_o;
   logic                       div_valid_o;
   logic                       div_ready_i;
   logic                       div_done_i;
   logic                       clk_en_o;
   logic                       busy_o;
   logic                       err_o;

   // master: requester plus divider side; slave: the sequencer
   modport master (
      output cfg_div_i, cfg_init_i, cfg_valid_i, div_ready_i, div_done_i,
      input  cfg_ready_o, div_o, clk_init_o, div_valid_o, clk_en_o, busy_o, err_o
   );
   modport slave (
      input  cfg_div_i, cfg_init_i, cfg_valid_i, div_ready_i, div_done_i,
      output cfg_ready_o, div_o, clk_init_o, div_valid_o, clk_en_o, busy_o, err_o
   );
endinterface

// File: rtl/clk_div_cfg_ctrl.sv
// Runtime reprogramming sequencer for an integer clock divider: gate, program, wait done, settle.
// Optional done-wait timeout with sticky err_o when CLK_DIV_CTRL_TIMEOUT_EN is defined.
module clk_div_cfg_ctrl #(
   parameter int          DIV_VALUE_WIDTH = 32,
   parameter int unsigned DEF_DIV         = 1,
   parameter int          GATE_CYCLES     = 4,
   parameter int          TIMEOUT_WIDTH   = 8
) (
   input logic               clk_i,
   input logic               rst_n_i,
   clk_div_cfg_ctrl_if.slave bus
);
   localparam int GW = (GATE_CYCLES < 2) ? 1 : $clog2(GATE_CYCLES);
   localparam logic [GW-1:0] GLAST = GW'(GATE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, GATE, PROG, WAIT_DONE, SETTLE} state_t;

   state_t                     state;
   logic [GW-1:0]              gcnt;
   logic [DIV_VALUE_WIDTH-1:0] div;
   logic                       init;
   logic                       div_valid;
   logic                       ready;
   logic                       clk_en;
   logic                       busy;
   logic                       accept;
   logic                       expire;

   assign accept = (state == IDLE) && bus.cfg_valid_i && ready;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= IDLE;
         gcnt      <= '0;
         div       <= DIV_VALUE_WIDTH'(DEF_DIV);
         init      <= 1'b0;
         div_valid <= 1'b0;
         ready     <= 1'b1;
         clk_en    <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  div    <= bus.cfg_div_i;
                  init   <= bus.cfg_init_i;
                  ready  <= 1'b0;
                  busy   <= 1'b1;
                  clk_en <= 1'b0;
                  gcnt   <= '0;
                  state  <= GATE;
               end
            end
            GATE: begin
               if (gcnt == GLAST) begin
                  gcnt      <= '0;
                  div_valid <= 1'b1;
                  state     <= PROG;
               end else begin
                  gcnt <= gcnt + 1'b1;
               end
            end
            PROG: begin
               if (bus.div_ready_i) begin
                  div_valid <= 1'b0;
                  state     <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               // done has priority over a coincident timeout expiry
               if (bus.div_done_i || expire) begin
                  gcnt  <= '0;
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               if (gcnt == GLAST) begin
                  gcnt   <= '0;
                  clk_en <= 1'b1;
                  ready  <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end else begin
                  gcnt <= gcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
   // Expiry fires on the cycle the wait count would reach all-ones.
   localparam logic [TIMEOUT_WIDTH-1:0] TLAST = ~TIMEOUT_WIDTH'(1);

   logic [TIMEOUT_WIDTH-1:0] tcnt;
   logic                     err;

   assign expire = (state == WAIT_DONE) && !bus.div_done_i && (tcnt == TLAST);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tcnt <= '0;
         err  <= 1'b0;
      end else begin
         if (accept)      err <= 1'b0;
         else if (expire) err <= 1'b1;
         if (state != WAIT_DONE)    tcnt <= '0;
         else if (!bus.div_done_i)  tcnt <= tcnt + 1'b1;
      end
   end

   assign bus.err_o = err;
`else
   assign expire    = 1'b0;
   assign bus.err_o = 1'b0;
   // nothing to build for the timeout in this configuration
   if (TIMEOUT_WIDTH < 1) begin : g_no_timeout
   end
`endif

   assign bus.cfg_ready_o = ready;
   assign bus.div_o       = div;
   assign bus.clk_init_o  = init;
   assign bus.div_valid_o = div_valid;
   assign bus.clk_en_o    = clk_en;
   assign bus.busy_o      = busy;
endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Randomized bench for clk_div_cfg_ctrl: a behavioural divider drives ready/done and
// each request's timing is predicted from the sequence rules with plain arithmetic.
module tb_clk_div_cfg_ctrl;
   localparam int          W   = 32;
   localparam int          G   = 4;
   localparam int          TW  = 4;
   localparam int unsigned DEF = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   dcnt    = 0;

   clk_div_cfg_ctrl_if #(.DIV_VALUE_WIDTH(W)) bus();

   clk_div_cfg_ctrl #(
      .DIV_VALUE_WIDTH(W), .DEF_DIV(DEF), .GATE_CYCLES(G), .TIMEOUT_WIDTH(TW)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One request end to end. dly<0 means the divider never reports done.
   task automatic run_req(input logic [W-1:0] dv, input logic init, input int stall,
                          input int dly, input bit poke, input bit exp_err);
      int lat, low, vld, hs, bad, st, exp_wait, exp_lat;
      bit back;
      chk("ready_pre", bus.cfg_ready_o, 1);
      bus.cfg_div_i   = dv;
      bus.cfg_init_i  = init;
      bus.cfg_valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cfg_valid_i = 1'b0;
      lat = 0; low = 0; vld = 0; hs = 0; bad = 0; st = 0; back = 0;
      for (int j = 0; j < 400 && !back; j++) begin
         if (j == 0) chk("err_clear", bus.err_o, 0);
         if (bus.cfg_ready_o) begin
            back = 1;
            lat  = j;
         end else begin
            if (!bus.clk_en_o) low++;
            if (bus.div_valid_o) vld++;
            if (bus.div_o !== dv || bus.clk_init_o !== init || bus.busy_o !== 1'b1) bad++;
            if (dcnt > 0) begin
               dcnt--;
               if (dcnt == 0) bus.div_done_i = 1'b1;
            end
            bus.div_ready_i = 1'b0;
            if (bus.div_valid_o) begin
               if (st < stall) st++;
               else begin
                  bus.div_ready_i = 1'b1;
                  hs++;
                  bus.div_done_i = 1'b0;
                  dcnt = (dly < 0) ? 0 : dly + 1;
               end
            end
            if (poke && j == 1) begin
               bus.cfg_div_i   = ~dv;
               bus.cfg_init_i  = ~init;
               bus.cfg_valid_i = 1'b1;
            end
            if (poke && j == 3) bus.cfg_valid_i = 1'b0;
            @(negedge clk);
         end
      end
      bus.div_ready_i = 1'b0;
      exp_wait = (dly < 0) ? (2**TW - 1) : dly + 1;
      exp_lat  = 2*G + (stall + 1) + exp_wait;
      chk("returned", back, 1);
      chk("latency", lat, exp_lat);
      chk("clk_en_low", low, exp_lat);
      chk("valid_cycles", vld, stall + 1);
      chk("handshakes", hs, 1);
      chk("stable_busy", bad, 0);
      chk("div_o", bus.div_o, dv);
      chk("clk_init_o", bus.clk_init_o, init);
      chk("clk_en_back", bus.clk_en_o, 1);
      chk("busy_idle", bus.busy_o, 0);
      chk("err", bus.err_o, exp_err);
   endtask

   initial begin
      bus.cfg_div_i   = '0;
      bus.cfg_init_i  = 1'b0;
      bus.cfg_valid_i = 1'b0;
      bus.div_ready_i = 1'b0;
      bus.div_done_i  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_clk_en", bus.clk_en_o, 1);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_div_o", bus.div_o, DEF);
      chk("idle_clk_en", bus.clk_en_o, 1);
      chk("idle_ready", bus.cfg_ready_o, 1);
      chk("idle_valid", bus.div_valid_o, 0);
      chk("idle_err", bus.err_o, 0);
      chk("idle_busy", bus.busy_o, 0);
      chk("idle_init", bus.clk_init_o, 0);

      run_req(32'd3, 1'b0, 0, 1, 1'b0, 1'b0);
      run_req(32'h55, 1'b1, 5, 1, 1'b1, 1'b0);
      run_req(32'd0, 1'b0, 0, 2, 1'b0, 1'b0);
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
      run_req(32'd9, 1'b0, 1, -1, 1'b0, 1'b1);
      run_req(32'd4, 1'b1, 0, 1, 1'b0, 1'b0);
`endif

      // Asynchronous reset while the config handshake is pending
      begin
         bit seen = 0;
         bus.cfg_div_i   = 32'd7;
         bus.cfg_init_i  = 1'b1;
         bus.cfg_valid_i = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bus.cfg_valid_i = 1'b0;
         bus.div_ready_i = 1'b0;
         for (int j = 0; j < 50 && !seen; j++) begin
            if (bus.div_valid_o) seen = 1;
            else @(negedge clk);
         end
         chk("reached_prog", seen, 1);
         #2 rst_n = 1'b0;
         #1;
         chk("rst_valid", bus.div_valid_o, 0);
         chk("rst_clk_en_mid", bus.clk_en_o, 1);
         chk("rst_div_o", bus.div_o, DEF);
         chk("rst_init", bus.clk_init_o, 0);
         chk("rst_ready", bus.cfg_ready_o, 1);
         chk("rst_busy", bus.busy_o, 0);
         @(negedge clk);
         rst_n = 1'b1;
         dcnt  = 0;
         @(negedge clk);
      end
      run_req(32'd6, 1'b0, 2, 3, 1'b0, 1'b0);

      for (int n = 0; n < 20; n++) begin
         logic [W-1:0] dv;
         dv = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
         run_req(dv, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                 int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), 1'b0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/clk_div_cfg_ctrl.md
Name: clk_div_cfg_ctrl

Overview:
Sequencer that safely reprograms an integer clock divider (divide ratio div+1, valid/ready config port, done flag) at runtime.
- Accepts a new divide value from a register-side requester.
- Gates the divided clock off, drives the divider's config handshake and waits for its done flag.
- Re-enables the clock.
- Sits between the clock/reset control register block and the divider + clock-gate cell.

Parameters:
DIV_VALUE_WIDTH, 32, width of divide value (ratio = value+1)
DEF_DIV, 1, div_o value after reset
GATE_CYCLES, 4, clk_i cycles clk_en_o is held low before programming and before re-enable (>=1)
TIMEOUT_WIDTH, 8, width of done-wait timeout counter (used only with CLK_DIV_CTRL_TIMEOUT_EN)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
cfg_div_i  in  DIV_VALUE_WIDTH  requested divide value
cfg_init_i  in  1  requested initial level of divided clock
cfg_valid_i  in  1  request valid
cfg_ready_o  out  1  controller can accept request
div_o  out  DIV_VALUE_WIDTH  registered divide value to divider
clk_init_o  out  1  registered initial level to divider
div_valid_o  out  1  divider config valid
div_ready_i  in  1  divider config ready
div_done_i  in  1  divider settled
clk_en_o  out  1  enable for downstream clock gate
busy_o  out  1  reconfiguration in progress
err_o  out  1  sticky timeout flag (0 when feature absent)

Behaviour:
- Reset: state IDLE, div_o=DEF_DIV, clk_init_o=0, div_valid_o=0, cfg_ready_o=1, clk_en_o=1, busy_o=0, err_o=0, gate counter=0.
- States: IDLE, GATE, PROG, WAIT_DONE, SETTLE.
- IDLE:
  - cfg_ready_o=1.
  - On cfg_valid_i&cfg_ready_o: latch cfg_div_i→div_o and cfg_init_i→clk_init_o, clear err_o, go GATE.
  - clk_en_o drops the cycle after acceptance.
- div_o/clk_init_o change only on acceptance; they are stable while div_valid_o=1 and while the divider runs.
- GATE:
  - clk_en_o=0.
  - Count GATE_CYCLES cycles, then go PROG.
- PROG:
  - div_valid_o=1; hold until div_ready_i=1.
  - On handshake go WAIT_DONE; div_valid_o=0 the next cycle.
  - Exactly one config handshake per accepted request.
- WAIT_DONE:
  - div_done_i is sampled from the first WAIT_DONE cycle; the divider clears done on the handshake edge.
  - On div_done_i=1 go SETTLE.
- SETTLE:
  - Count GATE_CYCLES cycles with clk_en_o=0, then go IDLE.
  - clk_en_o=1 on the IDLE entry cycle.
- Outside IDLE: busy_o=1 and cfg_ready_o=0. cfg_valid_i is ignored, and the requester holds the request.
- Minimum latency from accept to cfg_ready_o=1 = 2*GATE_CYCLES + 3 cycles, with div_ready_i=1 and done 1 cycle after handshake.
- Counters saturate/clear on state exit; no wrap-around behaviour is observable.
- div value 0 (bypass) is legal and goes through the same sequence.
- Asynchronous reset mid-sequence returns all outputs to reset values immediately; no partial handshake is remembered.

Optional Feature:
Macro CLK_DIV_CTRL_TIMEOUT_EN.
- Defined:
  - WAIT_DONE runs a TIMEOUT_WIDTH counter.
  - If it reaches all-ones without div_done_i: set err_o (sticky until next accepted request) and go SETTLE, so the clock is re-enabled.
  - div_done_i on the same cycle as expiry counts as done; err_o stays 0.
- Not defined: no counter; WAIT_DONE waits indefinitely; err_o tied 0.

Test Plan:
- Reset, then idle 10 cycles → div_o=1, clk_en_o=1, cfg_ready_o=1, div_valid_o=0, err_o=0.
- GATE_CYCLES=4, request div=3, init=0; divider ready=1, done 1 cycle after handshake → clk_en_o low 11 cycles; div_valid_o high exactly 1 cycle; div_o=3; cfg_ready_o=1 at accept+11.
- div_ready_i held low 5 cycles in PROG → div_valid_o held 5+1 cycles, div_o stable; a second cfg_valid_i during busy is not accepted.
- Request div=0 → sequence completes, div_o=0, clk_en_o returns to 1.
- TIMEOUT_EN, TIMEOUT_WIDTH=4, div_done_i stuck 0 → err_o=1 after 15 WAIT_DONE cycles, clk_en_o=1 after SETTLE; next request clears err_o.
- Assert rst_n_i during PROG → div_valid_o=0, clk_en_o=1, div_o=DEF_DIV immediately; a subsequent request completes normally.
